// File: rtl/mem_request_arbiter_if.sv
// Bundle of decoder/datapath request, response and RAM-side signals seen by
// the memory request arbiter. The arbiter sits on the slave modport; whatever
// drives requests and models the RAM sits on the master modport.
interface mem_request_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// Memory-side responder for instruction fetch and data load/store requests.
// Serialises them onto one single-port RAM with a ready handshake, data
// accesses first, and returns one-cycle hit pulses with registered load data.
// An access that waits TIMEOUT cycles without ramready is forced to complete,
// sets the sticky err flag and returns BAD_WORD on reads.
module mem_request_arbiter #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_request_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DACC   = 3'd1,
        IACC   = 3'd2,
        DHIT   = 3'd3,
        IHIT   = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_q;
    logic [31:0]        iload_q;
    logic [31:0]        dload_q;

    logic               tmo;
    logic               ram_ren;
    logic               ram_wen;
    logic [31:0]        ram_addr;
    logic [31:0]        ram_store;
    logic               ihit_c;
    logic               dhit_c;

    // Word-aligned RAM addressing ignores the byte-offset bits of both addresses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.iaddr[1:0], bus.daddr[1:0]};

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state selection and RAM strobes / hit pulses decoded from the state.
    always_comb begin
        nxt       = state;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = 32'h0;
        ram_store = 32'h0;
        ihit_c    = 1'b0;
        dhit_c    = 1'b0;
        tmo       = (wait_cnt == TMO_LAST) && !bus.ramready;
        case (state)
            IDLE: begin
                if (bus.halt) begin
                    nxt = HALTED;
                end else if (bus.dREN || bus.dWEN) begin
                    nxt = DACC;
                end else if (bus.iREN) begin
                    nxt = IACC;
                end
            end
            DACC: begin
                ram_addr  = {bus.daddr[31:2], 2'b00};
                ram_store = bus.dstore;
                // A write wins when both data strobes are raised together.
                if (bus.dWEN) begin
                    ram_wen = 1'b1;
                end else begin
                    ram_ren = 1'b1;
                end
                if (bus.ramready || tmo) begin
                    nxt = DHIT;
                end
            end
            IACC: begin
                ram_ren  = 1'b1;
                ram_addr = {bus.iaddr[31:2], 2'b00};
                if (bus.ramready || tmo) begin
                    nxt = IHIT;
                end
            end
            DHIT: begin
                dhit_c = 1'b1;
                nxt    = IDLE;
            end
            IHIT: begin
                ihit_c = 1'b1;
                nxt    = IDLE;
            end
            HALTED: begin
                nxt = HALTED;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // Wait counter, sticky timeout flag and the load-data registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
            iload_q  <= 32'h0;
            dload_q  <= 32'h0;
        end else begin
            case (state)
                DACC: begin
                    if (bus.ramready) begin
                        if (!bus.dWEN) begin
                            dload_q <= bus.ramload;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        if (!bus.dWEN) begin
                            dload_q <= BAD_WORD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                IACC: begin
                    if (bus.ramready) begin
                        iload_q <= bus.ramload;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        iload_q <= BAD_WORD;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Held at zero outside the access states so every access starts fresh.
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.ihit     = ihit_c;
    assign bus.dhit     = dhit_c;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: fetch, contention, write precedence,
// timeout, halt and asynchronous reset mid-access. Inputs change and outputs
// are checked on the falling clock edge.
module tb_mem_request_arbiter;

    logic CLK;
    logic RST;
    int   n_assert;
    int   n_fail;

    mem_request_arbiter_if bus();

    mem_request_arbiter #(
        .TIMEOUT  (16),
        .BAD_WORD (32'hBAD1BAD1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge CLK);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.halt     = 1'b0;
        bus.ramload  = 32'h0;
        bus.ramready = 1'b0;

        // Reset state
        nx();
        nx();
        chk("rst_ihit",   32'(bus.ihit),   32'h0);
        chk("rst_dhit",   32'(bus.dhit),   32'h0);
        chk("rst_err",    32'(bus.err),    32'h0);
        chk("rst_iload",  bus.iload,       32'h0);
        chk("rst_dload",  bus.dload,       32'h0);
        chk("rst_ramren", 32'(bus.ramREN), 32'h0);
        chk("rst_ramwen", 32'(bus.ramWEN), 32'h0);
        RST = 1'b0;

        // Fetch with ramready on the third driven cycle
        nx();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            nx();
            chk("f_ramren",  32'(bus.ramREN), 32'h1);
            chk("f_ramaddr", bus.ramaddr,     32'h40);
            chk("f_ihit0",   32'(bus.ihit),   32'h0);
            chk("f_dhit0",   32'(bus.dhit),   32'h0);
            if (i == 2) begin
                bus.ramready = 1'b1;
                bus.ramload  = 32'h3C01_0001;
            end
        end
        nx();
        chk("f_ihit",   32'(bus.ihit),   32'h1);
        chk("f_dhit",   32'(bus.dhit),   32'h0);
        chk("f_iload",  bus.iload,       32'h3C01_0001);
        chk("f_ramren_off", 32'(bus.ramREN), 32'h0);
        bus.ramready = 1'b0;
        bus.iREN     = 1'b0;
        nx();
        chk("f_ihit_once", 32'(bus.ihit), 32'h0);

        // Contention: data first, then fetch
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0080;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0103;
        nx();
        chk("c_d_ramren",  32'(bus.ramREN), 32'h1);
        chk("c_d_ramaddr", bus.ramaddr,     32'h100);
        chk("c_d_ramwen",  32'(bus.ramWEN), 32'h0);
        bus.ramready = 1'b1;
        bus.ramload  = 32'h1111_2222;
        nx();
        chk("c_dhit",  32'(bus.dhit), 32'h1);
        chk("c_ihit0", 32'(bus.ihit), 32'h0);
        chk("c_dload", bus.dload,     32'h1111_2222);
        bus.ramready = 1'b0;
        bus.dREN     = 1'b0;
        nx();
        chk("c_idle_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        chk("c_idle_ren",  32'(bus.ramREN), 32'h0);
        nx();
        chk("c_i_ramren",  32'(bus.ramREN), 32'h1);
        chk("c_i_ramaddr", bus.ramaddr,     32'h80);
        bus.ramready = 1'b1;
        bus.ramload  = 32'h3333_4444;
        nx();
        chk("c_ihit",  32'(bus.ihit), 32'h1);
        chk("c_dhit0", 32'(bus.dhit), 32'h0);
        chk("c_iload", bus.iload,     32'h3333_4444);
        bus.ramready = 1'b0;
        bus.iREN     = 1'b0;
        nx();

        // Write precedence over read
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.dstore = 32'hDEAD_BEEF;
        bus.daddr  = 32'h0000_0200;
        nx();
        chk("w_ramwen",   32'(bus.ramWEN), 32'h1);
        chk("w_ramren",   32'(bus.ramREN), 32'h0);
        chk("w_ramstore", bus.ramstore,    32'hDEAD_BEEF);
        chk("w_ramaddr",  bus.ramaddr,     32'h200);
        bus.ramready = 1'b1;
        bus.ramload  = 32'h5555_5555;
        nx();
        chk("w_dhit",  32'(bus.dhit), 32'h1);
        chk("w_dload", bus.dload,     32'h1111_2222);
        bus.ramready = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        nx();

        // Timeout on a data read
        chk("t_err_before", 32'(bus.err), 32'h0);
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0300;
        for (int i = 0; i < 16; i++) begin
            nx();
            chk("t_wait_ren",  32'(bus.ramREN), 32'h1);
            chk("t_wait_dhit", 32'(bus.dhit),   32'h0);
        end
        chk("t_err_late", 32'(bus.err), 32'h0);
        nx();
        chk("t_dhit",  32'(bus.dhit), 32'h1);
        chk("t_err",   32'(bus.err),  32'h1);
        chk("t_dload", bus.dload,     32'hBAD1_BAD1);
        bus.dREN = 1'b0;
        nx();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0304;
        nx();
        bus.ramready = 1'b1;
        bus.ramload  = 32'h7777_8888;
        nx();
        chk("t2_dhit",  32'(bus.dhit), 32'h1);
        chk("t2_dload", bus.dload,     32'h7777_8888);
        chk("t2_err",   32'(bus.err),  32'h1);
        bus.ramready = 1'b0;
        bus.dREN     = 1'b0;
        nx();

        // Halt raised during a data access
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0400;
        nx();
        bus.halt = 1'b1;
        nx();
        chk("h_ramren", 32'(bus.ramREN), 32'h1);
        bus.ramready = 1'b1;
        bus.ramload  = 32'h9999_AAAA;
        nx();
        chk("h_dhit",  32'(bus.dhit), 32'h1);
        chk("h_dload", bus.dload,     32'h9999_AAAA);
        bus.ramready = 1'b0;
        bus.dREN     = 1'b0;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0500;
        for (int i = 0; i < 20; i++) begin
            nx();
            chk("h_quiet", {30'h0, bus.ramREN, bus.ihit}, 32'h0);
            bus.ramready = 1'b1;
        end
        chk("h_iload_hold", bus.iload, 32'h3333_4444);
        bus.ramready = 1'b0;
        bus.iREN     = 1'b0;
        bus.halt     = 1'b0;

        // Asynchronous reset in the middle of a fetch
        RST = 1'b1;
        nx();
        RST = 1'b0;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0600;
        nx();
        chk("r_ramren_pre", 32'(bus.ramREN), 32'h1);
        nx();
        #2;
        RST = 1'b1;
        #1;
        chk("r_ramren_drop", 32'(bus.ramREN), 32'h0);
        chk("r_ihit_none",   32'(bus.ihit),   32'h0);
        chk("r_err_clear",   32'(bus.err),    32'h0);
        nx();
        chk("r_ihit_none2", 32'(bus.ihit), 32'h0);
        RST = 1'b0;
        nx();
        chk("r2_ramren",  32'(bus.ramREN), 32'h1);
        chk("r2_ramaddr", bus.ramaddr,     32'h600);
        bus.ramready = 1'b1;
        bus.ramload  = 32'hCAFE_F00D;
        nx();
        chk("r2_ihit",  32'(bus.ihit), 32'h1);
        chk("r2_iload", bus.iload,     32'hCAFE_F00D);
        bus.ramready = 1'b0;
        bus.iREN     = 1'b0;
        nx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
